// File: rtl/line_engine_pkg.sv
// Shared types and constants for the line-drawing engine: FSM encoding,
// coordinate/error widths, frame-buffer base and pixel address helper.
package line_engine_pkg;

    localparam int          COORD_W         = 10;
    localparam int          ERR_W           = 12;
    localparam logic [31:0] FB_BASE_DEFAULT = 32'h1040_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [ERR_W-1:0] err_t;

    // Byte address of pixel (x,y): base + {y, x, 2'b00}
    function automatic logic [31:0] pixel_addr(logic [31:0] base, coord_t x, coord_t y);
        return base + {10'd0, y, x, 2'b00};
    endfunction

endpackage

// File: rtl/line_engine_if.sv
// Command port from the core plus frame-buffer write port to the arbiter.
// master = core/arbiter side, slave = line engine.
interface line_engine_if;
    import line_engine_pkg::*;

    logic [31:0] line_color;
    coord_t      line_point;
    logic        line_color_valid;
    logic        line_x0_valid;
    logic        line_y0_valid;
    logic        line_x1_valid;
    logic        line_y1_valid;
    logic        line_trigger;
    logic        line_ready;
    logic [31:0] px_addr;
    logic [31:0] px_data;
    logic [3:0]  px_we;
    logic        px_valid;
    logic        px_ready;

    modport master (
        output line_color, line_point, line_color_valid, line_x0_valid, line_y0_valid,
               line_x1_valid, line_y1_valid, line_trigger, px_ready,
        input  line_ready, px_addr, px_data, px_we, px_valid
    );

    modport slave (
        input  line_color, line_point, line_color_valid, line_x0_valid, line_y0_valid,
               line_x1_valid, line_y1_valid, line_trigger, px_ready,
        output line_ready, px_addr, px_data, px_we, px_valid
    );

endinterface

// File: rtl/line_engine_step.sv
// Combinational Bresenham step: current point and error -> next point and error,
// plus endpoint detect.
module line_step
    import line_engine_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    input  coord_t x1,
    input  coord_t y1,
    input  err_t   err,
    input  err_t   dx,
    input  err_t   dy,
    input  logic   sx_neg,
    input  logic   sy_neg,
    output coord_t x_nxt,
    output coord_t y_nxt,
    output err_t   err_nxt,
    output logic   at_end
);

    // One extra bit so 2*err cannot overflow.
    logic signed [ERR_W:0] err_w, dx_w, dy_w, e2, err_acc;

    always_comb begin
        err_w   = (ERR_W+1)'(err);
        dx_w    = (ERR_W+1)'(dx);
        dy_w    = (ERR_W+1)'(dy);
        e2      = err_w + err_w;
        err_acc = err_w;
        x_nxt   = x;
        y_nxt   = y;
        if (e2 >= dy_w) begin
            err_acc = err_acc + dy_w;
            x_nxt   = sx_neg ? x - 10'd1 : x + 10'd1;
        end
        if (e2 <= dx_w) begin
            err_acc = err_acc + dx_w;
            y_nxt   = sy_neg ? y - 10'd1 : y + 10'd1;
        end
        err_nxt = err_acc[ERR_W-1:0];
        at_end  = (x == x1) && (y == y1);
    end

endmodule

// File: rtl/line_engine.sv
// Line-drawing responder: captures operands, rasterises with Bresenham and issues
// one frame-buffer write per handshake. Define LINE_CLIP_EN to skip off-screen pixels.
//
//   state    | meaning
//   ST_IDLE  | line_ready high, operand strobes and trigger accepted
//   ST_SETUP | one cycle computing dx/dy/sx/sy/err from captured operands
//   ST_DRAW  | presenting pixel (x,y) until accepted; endpoint returns to idle
module line_engine
    import line_engine_pkg::*;
#(
    parameter logic [31:0] FB_BASE = FB_BASE_DEFAULT
`ifdef LINE_CLIP_EN
    ,
    parameter int          WIDTH   = 800,
    parameter int          HEIGHT  = 600
`endif
) (
    input  logic          clk,
    input  logic          rst,
    line_engine_if.slave  bus
);

    state_t      state, state_nxt;
    coord_t      x0, y0, x1, y1, x, y, x_nxt, y_nxt;
    logic [23:0] color;
    err_t        err, dx, dy, err_nxt;
    err_t        diff_x, diff_y, abs_x, abs_y;
    logic        sx_neg, sy_neg, at_end, in_bounds, advance;
    logic        ready_c, valid_c;
    logic [31:0] addr_c, data_c;
    logic [3:0]  we_c;

    line_step u_step (
        .x      (x),
        .y      (y),
        .x1     (x1),
        .y1     (y1),
        .err    (err),
        .dx     (dx),
        .dy     (dy),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .x_nxt  (x_nxt),
        .y_nxt  (y_nxt),
        .err_nxt(err_nxt),
        .at_end (at_end)
    );

`ifdef LINE_CLIP_EN
    localparam logic [COORD_W:0] WIDTH_L  = (COORD_W+1)'(WIDTH);
    localparam logic [COORD_W:0] HEIGHT_L = (COORD_W+1)'(HEIGHT);
    assign in_bounds = ({1'b0, x} < WIDTH_L) && ({1'b0, y} < HEIGHT_L);
`else
    assign in_bounds = 1'b1;
`endif

    // Off-screen pixels advance on their own; visible ones wait for the arbiter.
    assign advance = (valid_c && bus.px_ready) || ((state == ST_DRAW) && !in_bounds);

    always_comb begin
        diff_x = $signed({2'b00, x1}) - $signed({2'b00, x0});
        diff_y = $signed({2'b00, y1}) - $signed({2'b00, y0});
        abs_x  = diff_x[ERR_W-1] ? -diff_x : diff_x;
        abs_y  = diff_y[ERR_W-1] ? -diff_y : diff_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.line_trigger) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_DRAW;
            ST_DRAW:  if (advance && at_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_c = (state == ST_IDLE);
        valid_c = (state == ST_DRAW) && in_bounds;
        we_c    = valid_c ? 4'hF : 4'h0;
        addr_c  = valid_c ? pixel_addr(FB_BASE, x, y) : 32'h0;
        data_c  = valid_c ? {8'h00, color} : 32'h0;
    end

    assign bus.line_ready = ready_c;
    assign bus.px_valid   = valid_c;
    assign bus.px_we      = we_c;
    assign bus.px_addr    = addr_c;
    assign bus.px_data    = data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0     <= '0;
            y0     <= '0;
            x1     <= '0;
            y1     <= '0;
            color  <= '0;
            x      <= '0;
            y      <= '0;
            err    <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.line_color_valid) color <= bus.line_color[23:0];
                    if (bus.line_x0_valid)    x0    <= bus.line_point;
                    if (bus.line_y0_valid)    y0    <= bus.line_point;
                    if (bus.line_x1_valid)    x1    <= bus.line_point;
                    if (bus.line_y1_valid)    y1    <= bus.line_point;
                end
                ST_SETUP: begin
                    x      <= x0;
                    y      <= y0;
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    err    <= abs_x - abs_y;
                    sx_neg <= !(x0 < x1);
                    sy_neg <= !(y0 < y1);
                end
                ST_DRAW: begin
                    if (advance && !at_end) begin
                        x   <= x_nxt;
                        y   <= y_nxt;
                        err <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_engine.sv
// Scoreboard bench for line_engine: expected pixel writes are queued when a line is
// started and popped by a monitor on every accepted px_valid/px_ready handshake.
module tb_line_engine;
    import line_engine_pkg::*;

    localparam logic [31:0] FB = 32'h1040_0000;
`ifdef LINE_CLIP_EN
    localparam int TB_W = 4;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } px_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   accept_cnt = 0;
    px_t  sb[$];

    line_engine_if bus ();

    line_engine #(
        .FB_BASE(FB)
`ifdef LINE_CLIP_EN
        ,
        .WIDTH  (TB_W),
        .HEIGHT (600)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        px_t e;
        if (rst === 1'b0 && bus.px_valid === 1'b1 && bus.px_ready === 1'b1) begin
            accept_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h required none", bus.px_addr, bus.px_data);
            end else begin
                e = sb.pop_front();
                if (bus.px_addr !== e.addr || bus.px_data !== e.data || bus.px_we !== 4'hF) begin
                    failures++;
                    $display("FAIL px_write got addr=%h data=%h we=%h required addr=%h data=%h we=f",
                             bus.px_addr, bus.px_data, bus.px_we, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.line_color_valid = 1'b0;
        bus.line_x0_valid    = 1'b0;
        bus.line_y0_valid    = 1'b0;
        bus.line_x1_valid    = 1'b0;
        bus.line_y1_valid    = 1'b0;
        bus.line_trigger     = 1'b0;
    endtask

    task automatic push_px(int px, int py, logic [23:0] c);
        px_t p;
        p.addr = FB + 32'(py * 4096 + px * 4);
        p.data = {8'h00, c};
        sb.push_back(p);
    endtask

    // Reference integer Bresenham producing the expected write sequence.
    task automatic model_line(int ax, int ay, int bx, int by, logic [23:0] c);
        int dx, dy, sx, sy, err, e2, cx, cy;
        dx  = (bx > ax) ? bx - ax : ax - bx;
        dy  = (by > ay) ? ay - by : by - ay;
        sx  = (ax < bx) ? 1 : -1;
        sy  = (ay < by) ? 1 : -1;
        err = dx + dy;
        cx  = ax;
        cy  = ay;
        for (int n = 0; n < 4096; n++) begin
`ifdef LINE_CLIP_EN
            if (cx < TB_W) push_px(cx, cy, c);
`else
            push_px(cx, cy, c);
`endif
            if (cx == bx && cy == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    // Strobes colour+x0, then y0, x1, and finally y1 together with the trigger.
    task automatic load_and_trigger(int ax, int ay, int bx, int by, logic [23:0] c);
        bus.line_color = {8'hA5, c};
        bus.line_color_valid = 1'b1;
        bus.line_point = 10'(ax);
        bus.line_x0_valid = 1'b1;
        tick();
        idle_inputs();
        bus.line_point = 10'(ay);
        bus.line_y0_valid = 1'b1;
        tick();
        idle_inputs();
        bus.line_point = 10'(bx);
        bus.line_x1_valid = 1'b1;
        tick();
        idle_inputs();
        bus.line_point = 10'(by);
        bus.line_y1_valid = 1'b1;
        bus.line_trigger = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (bus.line_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bus.line_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got line_ready=%b required 1 within %0d cycles", name, bus.line_ready, budget);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding required 0", name, sb.size());
        end
    endtask

    task automatic check_count(string name, int a0, int exp_n);
        checks++;
        if (accept_cnt - a0 !== exp_n) begin
            failures++;
            $display("FAIL %s_count got %0d writes required %0d", name, accept_cnt - a0, exp_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.line_ready !== 1'b1 || bus.px_valid !== 1'b0 || bus.px_we !== 4'h0 ||
            bus.px_addr !== 32'h0 || bus.px_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b we=%h addr=%h data=%h required 1 0 0 0 0",
                     bus.line_ready, bus.px_valid, bus.px_we, bus.px_addr, bus.px_data);
        end
        rst = 1'b0;
        tick();
    endtask

    // Trigger with no strobes: operands all zero -> single pixel (0,0), colour 0.
    task automatic test_zero_operands(string name);
        int a0 = accept_cnt;
        bus.px_ready = 1'b1;
        push_px(0, 0, 24'h0);
        bus.line_trigger = 1'b1;
        tick();
        idle_inputs();
        wait_idle(name, 20);
        check_count(name, a0, 1);
    endtask

    task automatic test_horizontal();
        int a0 = accept_cnt;
        px_t p;
        logic [31:0] addrs[4];
        addrs = '{FB + 32'h0, FB + 32'h4, FB + 32'h8, FB + 32'hC};
        bus.px_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p.addr = addrs[i];
            p.data = 32'h0012_3456;
            sb.push_back(p);
        end
        load_and_trigger(0, 0, 3, 0, 24'h123456);
        checks++;
        if (bus.px_valid !== 1'b0 || bus.line_ready !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1 got valid=%b ready=%b required 0 0", bus.px_valid, bus.line_ready);
        end
        tick();
        checks++;
        if (bus.px_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_t2 got valid=%b required 1", bus.px_valid);
        end
        wait_idle("horizontal", 30);
        check_count("horizontal", a0, 4);
    endtask

    task automatic test_steep();
        int a0 = accept_cnt;
        int xs[5];
        int ys[5];
        xs = '{2, 2, 3, 3, 3};
        ys = '{1, 2, 3, 4, 5};
        bus.px_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_px(xs[i], ys[i], 24'h00FF00);
        load_and_trigger(2, 1, 3, 5, 24'h00FF00);
        wait_idle("steep", 30);
        check_count("steep", a0, 5);
    endtask

    task automatic test_reverse();
        int a0 = accept_cnt;
        bus.px_ready = 1'b1;
        model_line(5, 5, 0, 0, 24'hC0FFEE);
        load_and_trigger(5, 5, 0, 0, 24'hC0FFEE);
        wait_idle("reverse", 30);
        check_count("reverse", a0, 6);
    endtask

    task automatic test_backpressure();
        int a0 = accept_cnt;
        int stalls = 0;
        logic stalled_prev = 1'b0;
        logic [31:0] prev_addr = '0;
        bus.px_ready = 1'b0;
        model_line(0, 0, 2, 0, 24'h0A0B0C);
        load_and_trigger(0, 0, 2, 0, 24'h0A0B0C);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (stalled_prev) begin
                checks++;
                if (bus.px_valid !== 1'b1 || bus.px_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%b addr=%h required 1 %h", bus.px_valid, bus.px_addr, prev_addr);
                end
            end
            stalled_prev = bus.px_valid && !bus.px_ready;
            if (stalled_prev) stalls++;
            prev_addr = bus.px_addr;
            if (bus.line_ready === 1'b1) break;
            @(posedge clk);
            #1;
            bus.px_ready = ~bus.px_ready;
        end
        tick();
        wait_idle("backpressure", 10);
        check_count("backpressure", a0, 3);
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL stall_seen got %0d stalls required >0", stalls);
        end
        bus.px_ready = 1'b1;
    endtask

    task automatic test_coincident_and_busy();
        int a0 = accept_cnt;
        bus.px_ready = 1'b1;
        for (int k = 0; k <= 7; k++) push_px(0, k, 24'hAABBCC);
        load_and_trigger(0, 0, 0, 7, 24'hAABBCC);
        bus.line_point = 10'd9;
        bus.line_x1_valid = 1'b1;
        bus.line_color = 32'h0011_2233;
        bus.line_color_valid = 1'b1;
        bus.line_trigger = 1'b1;
        tick();
        idle_inputs();
        bus.line_point = 10'd2;
        bus.line_y1_valid = 1'b1;
        tick();
        idle_inputs();
        wait_idle("coincident", 30);
        check_count("coincident", a0, 8);
        // Busy-time strobes must not have reached the operand registers.
        a0 = accept_cnt;
        for (int k = 0; k <= 7; k++) push_px(0, k, 24'hAABBCC);
        bus.line_trigger = 1'b1;
        tick();
        idle_inputs();
        wait_idle("busy_ignored", 30);
        check_count("busy_ignored", a0, 8);
    endtask

    task automatic test_reset_mid_line();
        logic found = 1'b0;
        bus.px_ready = 1'b1;
        push_px(0, 0, 24'h555555);
        push_px(1, 0, 24'h555555);
        load_and_trigger(0, 0, 9, 0, 24'h555555);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.px_valid === 1'b1 && bus.px_addr === FB + 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL third_pixel got found=0 required 1");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.px_valid !== 1'b0 || bus.line_ready !== 1'b1 || bus.px_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b ready=%b addr=%h required 0 1 0",
                     bus.px_valid, bus.line_ready, bus.px_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_pending got %0d required 0", sb.size());
        end
        test_zero_operands("after_reset");
    endtask

`ifdef LINE_CLIP_EN
    task automatic test_clip();
        int a0 = accept_cnt;
        bus.px_ready = 1'b1;
        model_line(0, 0, 7, 0, 24'h777777);
        load_and_trigger(0, 0, 7, 0, 24'h777777);
        wait_idle("clip", 30);
        check_count("clip", a0, 4);
    endtask
`endif

    initial begin
        bus.line_color = '0;
        bus.line_point = '0;
        bus.px_ready   = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_operands("zero_operands");
        test_horizontal();
        test_steep();
        test_reverse();
        test_backpressure();
        test_coincident_and_busy();
        test_reset_mid_line();
`ifdef LINE_CLIP_EN
        test_clip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
